// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall scheduler.
//   STOP/NOSTOP     : per-stage hold flag values on the stall bus
//   stall_bus_t     : [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
//   STALL_*         : the three stall codes the scheduler can emit
//   mc_state_e      : multi-cycle occupancy FSM states
//   stall_code()    : priority merge of multi-cycle and load-use requests
package pipe_stall_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;

  // Stage i holds when its bit is STOP; the lowest NOSTOP stage above a STOP
  // receives a bubble. LOAD_USE bubbles into EX, MULTI bubbles into MEM.
  localparam stall_bus_t STALL_NONE     = 6'b000000;
  localparam stall_bus_t STALL_LOAD_USE = 6'b000111;
  localparam stall_bus_t STALL_MULTI    = 6'b001111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_e;

  // MULTI is a superset of LOAD_USE, so it wins when both are requested.
  function automatic stall_bus_t stall_code(input logic mc_req, input logic id_req);
    if (mc_req) return STALL_MULTI;
    if (id_req) return STALL_LOAD_USE;
    return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the ID/EX stages and the stall scheduler.
//   stallreq_id   : ID load-use hazard (level)
//   ex_mc_start   : EX issues a multi-cycle op (1-cycle pulse)
//   ex_mc_is_div  : qualifies ex_mc_start, 1=divide 0=multiply
//   stall         : merged stall bus to all pipeline registers
//   mc_busy       : multi-cycle op in flight
//   mc_done       : last stall cycle of the op, EX presents its result
//   stall_cycles  : saturating count of cycles with a non-zero stall
// modport master : pipeline side (drives requests)
// modport slave  : scheduler side (drives stall/status)
interface pipe_stall_ctrl_if;
  import pipe_stall_ctrl_pkg::*;

  logic        stallreq_id;
  logic        ex_mc_start;
  logic        ex_mc_is_div;
  stall_bus_t  stall;
  logic        mc_busy;
  logic        mc_done;
  logic [31:0] stall_cycles;

  modport master (
    output stallreq_id, ex_mc_start, ex_mc_is_div,
    input  stall, mc_busy, mc_done, stall_cycles
  );

  modport slave (
    input  stallreq_id, ex_mc_start, ex_mc_is_div,
    output stall, mc_busy, mc_done, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter32.sv
// 32-bit up counter that sticks at all-ones instead of wrapping.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears the count
//   i_en    : count this cycle
//   o_count : current count
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall scheduler for the 5-stage pipeline. Merges the ID load-use
// request with EX multi-cycle (mul/div) requests into one stall bus, owns the
// multi-cycle occupancy FSM and counter, and counts stalled cycles.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pipe_stall_ctrl_if.slave (requests in, stall/status out)
// Parameters: DIV_CYCLES / MUL_CYCLES total stall cycles per op (>=2),
// CNT_W wide enough to hold max(DIV_CYCLES, MUL_CYCLES)-1.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 33,
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stall_ctrl_if.slave     bus
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  mc_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mc_busy;
  logic             r_mc_done;

  logic             w_mc_take;
  logic [CNT_W-1:0] w_load;
  stall_bus_t       w_stall;

  // A start is only accepted from RUN; a start while BUSY cannot happen in a
  // correct pipeline because EX is frozen, so it is simply ignored here.
  assign w_mc_take = (r_state == ST_RUN) && bus.ex_mc_start;
  assign w_load    = bus.ex_mc_is_div ? DIV_LOAD : MUL_LOAD;

  // The start cycle itself already stalls, so the counter is loaded with N-1
  // and the op occupies exactly N cycles. Stall depends only on the registered
  // state plus the raw requests, never on mc_done/mc_busy.
  always_comb begin
    w_stall = STALL_NONE;
    if (!rst) begin
      w_stall = stall_code(w_mc_take || (r_state == ST_BUSY), bus.stallreq_id);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_mc_busy <= 1'b0;
      r_mc_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.ex_mc_start) begin
            r_state   <= ST_BUSY;
            r_cnt     <= w_load;
            r_mc_busy <= 1'b1;
            // With a 2-cycle op the very first BUSY cycle is the last one.
            r_mc_done <= (w_load == CNT_ONE);
          end else begin
            r_mc_busy <= 1'b0;
            r_mc_done <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (r_cnt == CNT_ONE) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_mc_busy <= 1'b0;
            r_mc_done <= 1'b0;
          end else begin
            r_cnt     <= r_cnt - CNT_ONE;
            r_mc_busy <= 1'b1;
            r_mc_done <= (r_cnt == CNT_TWO);
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_cnt     <= '0;
          r_mc_busy <= 1'b0;
          r_mc_done <= 1'b0;
        end
      endcase
    end
  end

  sat_counter32 u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_stall != STALL_NONE),
    .o_count (bus.stall_cycles)
  );

  assign bus.stall   = w_stall;
  assign bus.mc_busy = r_mc_busy;
  assign bus.mc_done = r_mc_done;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle against
// a behavioural model that tracks "stall cycles remaining" for the current op.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  localparam int DIV_N = 33;
  localparam int MUL_N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(
    .DIV_CYCLES (DIV_N),
    .MUL_CYCLES (MUL_N),
    .CNT_W      (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: m_left = stall cycles still owed to the current
  // multi-cycle op (0 when none); m_cycles = expected stall_cycles value.
  int              m_left   = 0;
  longint unsigned m_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare process, 2 time units after the input-drive edge.
  always @(negedge clk) begin
    logic       busy_e;
    logic       done_e;
    stall_bus_t stall_e;
    #2;
    if (rst) begin
      m_left   = 0;
      m_cycles = 0;
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_busy", 32'(bus.mc_busy), 32'd0);
      check("rst_done", 32'(bus.mc_done), 32'd0);
      check("rst_cycles", bus.stall_cycles, 32'd0);
    end else begin
      busy_e = (m_left > 0);
      if (busy_e && bus.ex_mc_start) begin
        n_checks++;
        $display("FAIL start_while_busy issued by stimulus at %0t", $time);
      end
      if (!busy_e && bus.ex_mc_start) m_left = bus.ex_mc_is_div ? DIV_N : MUL_N;
      if (m_left > 0)            stall_e = STALL_MULTI;
      else if (bus.stallreq_id)  stall_e = STALL_LOAD_USE;
      else                       stall_e = STALL_NONE;
      done_e = busy_e && (m_left == 1);
      check("model_stall", 32'(bus.stall), 32'(stall_e));
      check("model_busy", 32'(bus.mc_busy), 32'(busy_e));
      check("model_done", 32'(bus.mc_done), 32'(done_e));
      check("model_cycles", bus.stall_cycles, m_cycles[31:0]);
      if (stall_e != STALL_NONE && m_cycles < 64'hFFFF_FFFF) m_cycles++;
      if (m_left > 0) m_left--;
    end
  end

  // Drive one cycle of inputs on the falling edge, then settle past the compare.
  task automatic drive(input logic r, input logic id, input logic st, input logic dv);
    @(negedge clk);
    rst              = r;
    bus.stallreq_id  = id;
    bus.ex_mc_start  = st;
    bus.ex_mc_is_div = dv;
    #3;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    check("lit_rst_stall", 32'(bus.stall), 32'd0);
    check("lit_rst_cycles", bus.stall_cycles, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full divide from a zeroed counter: 33 MULTI cycles, one mc_done at T+32.
  task automatic run_div(input string tag);
    int multi_cnt = 0;
    int done_cnt  = 0;
    int done_idx  = -1;
    logic [5:0] stall_after = '1;
    for (int k = 0; k < 35; k++) begin
      drive(1'b0, 1'b0, k == 0, 1'b1);
      if (bus.stall == STALL_MULTI) multi_cnt++;
      if (bus.mc_done) begin done_cnt++; done_idx = k; end
      if (k == 33) stall_after = bus.stall;
    end
    check({tag, "_multi_cycles"}, 32'(multi_cnt), 32'd33);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_index"}, 32'(done_idx), 32'd32);
    check({tag, "_stall_released"}, 32'(stall_after), 32'd0);
    check({tag, "_stall_cycles"}, bus.stall_cycles, 32'd33);
    $display("txn %s: multi=%0d done_at=%0d stall_cycles=%0d", tag, multi_cnt, done_idx, bus.stall_cycles);
  endtask

  initial begin
    logic [5:0] exp_st [5];
    logic       exp_dn [5];
    int         done_seen;

    bus.stallreq_id  = 1'b0;
    bus.ex_mc_start  = 1'b0;
    bus.ex_mc_is_div = 1'b0;

    // Reset with random inputs held high.
    do_reset();
    $display("txn reset: stall=%b cycles=%0d", bus.stall, bus.stall_cycles);

    // Single-cycle load-use.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("lu_stall", 32'(bus.stall), 32'b000111);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_release", 32'(bus.stall), 32'd0);
    check("lu_cycles", bus.stall_cycles, 32'd1);
    $display("txn load_use: stall_cycles=%0d", bus.stall_cycles);

    // Divide.
    do_reset();
    run_div("div");

    // Multiply with simultaneous, held load-use request.
    do_reset();
    exp_st = '{6'b001111, 6'b001111, 6'b000111, 6'b000111, 6'b000000};
    exp_dn = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, k < 4, k == 0, 1'b0);
      check($sformatf("mul_lu_stall_%0d", k), 32'(bus.stall), 32'(exp_st[k]));
      check($sformatf("mul_lu_done_%0d", k), 32'(bus.mc_done), 32'(exp_dn[k]));
    end
    check("mul_lu_cycles", bus.stall_cycles, 32'd4);
    $display("txn mul_plus_load_use: stall_cycles=%0d", bus.stall_cycles);

    // Reset in the middle of a divide aborts it without mc_done.
    do_reset();
    done_seen = 0;
    for (int k = 0; k < 13; k++) begin
      drive(k == 10, 1'b0, k == 0, 1'b1);
      if (bus.mc_done) done_seen++;
      if (k == 11) check("abort_busy", 32'(bus.mc_busy), 32'd0);
      if (k == 12) check("abort_stall", 32'(bus.stall), 32'd0);
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    $display("txn div_abort: done_seen=%0d", done_seen);
    run_div("div_after_abort");

    // Saturation of the stall-cycle counter.
    @(negedge clk);
    force dut.u_stall_cnt.r_count = 32'hFFFF_FFFE;
    m_cycles = 64'hFFFF_FFFE;
    rst             = 1'b0;
    bus.stallreq_id = 1'b1;
    bus.ex_mc_start = 1'b0;
    #1;
    release dut.u_stall_cnt.r_count;
    #2;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_hold", bus.stall_cycles, 32'hFFFF_FFFF);
    $display("txn saturate: stall_cycles=%h", bus.stall_cycles);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      logic r, id, st, dv;
      r  = ($urandom_range(0, 199) == 0);
      id = ($urandom_range(0, 3) == 0);
      dv = ($urandom_range(0, 2) == 0);
      st = (m_left == 0) && ($urandom_range(0, 7) == 0);
      drive(r, id, st, dv);
      if (r) drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
